// File: rtl/seq_trunc_mult.sv
// Iterative radix-2 shift-add unsigned multiplier returning the top
// RESULT_BIT_WIDTH bits of the product, with truncate or round-half-up
// (saturating) modes and an inexact flag, behind valid/ready handshakes.
module seq_trunc_mult #(
  parameter int BIT_WIDTH        = 6,
  parameter int RESULT_BIT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BIT_WIDTH-1:0]       op_x,
  input  logic [BIT_WIDTH-1:0]       op_y,
  input  logic                       round_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RESULT_BIT_WIDTH-1:0] result,
  output logic                       inexact,
  output logic [2*BIT_WIDTH-1:0]     product_full
);

  localparam int W  = BIT_WIDTH;
  localparam int RW = RESULT_BIT_WIDTH;
  localparam int S  = 2 * W - RW;
  localparam int CW = $clog2(W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MUL   = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]     state;
  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic           mode;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic [RW-1:0]  round_res;
  logic           round_inx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  generate
    if (S > 0) begin : g_round
      // Adding 2^(S-1) to P carries into bit S exactly when P[S-1] is set,
      // so the rounded top field is P[2W-1:S] + P[S-1]; its carry-out is T[2W].
      logic [RW:0] t_hi;
      assign t_hi      = {1'b0, acc[2*W-1:S]} + (RW+1)'(acc[S-1]);
      assign round_inx = |acc[S-1:0];
      assign round_res = !mode ? acc[2*W-1:S] : (t_hi[RW] ? '1 : t_hi[RW-1:0]);
    end else begin : g_exact
      assign round_inx = 1'b0;
      assign round_res = acc;
    end
  endgenerate

  // Control FSM, shift-add datapath and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      mcand        <= '0;
      mplier       <= '0;
      mode         <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      result       <= '0;
      inexact      <= 1'b0;
      product_full <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand  <= {{W{1'b0}}, op_x};
            mplier <= op_y;
            mode   <= round_mode;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          // Multiplicand pre-shifted by i and multiplier shifted right,
          // so iteration i adds op_x<<i when op_y[i] is set.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= ROUND;
        end
        ROUND: begin
          result       <= round_res;
          inexact      <= round_inx;
          product_full <= acc;
          state        <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_trunc_mult.sv
// Self-checking bench for seq_trunc_mult: directed cases plus randomized
// operations on a W=6/RW=8 and a W=4/RW=2 instance, against an arithmetic model.
module tb_seq_trunc_mult;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic        in_valid_a, in_ready_a, round_mode_a, out_valid_a, out_ready_a, inexact_a;
  logic [5:0]  op_x_a, op_y_a;
  logic [7:0]  result_a;
  logic [11:0] product_full_a;

  logic        in_valid_b, in_ready_b, round_mode_b, out_valid_b, out_ready_b, inexact_b;
  logic [3:0]  op_x_b, op_y_b;
  logic [1:0]  result_b;
  logic [7:0]  product_full_b;

  seq_trunc_mult #(.BIT_WIDTH(6), .RESULT_BIT_WIDTH(8)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .op_x(op_x_a), .op_y(op_y_a), .round_mode(round_mode_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .result(result_a), .inexact(inexact_a), .product_full(product_full_a)
  );

  seq_trunc_mult #(.BIT_WIDTH(4), .RESULT_BIT_WIDTH(2)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .op_x(op_x_b), .op_y(op_y_b), .round_mode(round_mode_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .result(result_b), .inexact(inexact_b), .product_full(product_full_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: top bits of the exact product, optionally rounded half-up and saturated.
  task automatic model(input int inst, input int x, input int y, input int m,
                       output logic [63:0] res, output logic [63:0] inx, output logic [63:0] pf);
    int w, rw, s;
    logic [63:0] p, r, maxv;
    w    = (inst != 0) ? 4 : 6;
    rw   = (inst != 0) ? 2 : 8;
    s    = 2 * w - rw;
    p    = 64'(x) * 64'(y);
    maxv = (64'd1 << rw) - 64'd1;
    if (m != 0 && s > 0) r = (p + (64'd1 << (s - 1))) >> s;
    else                 r = p >> s;
    if (r > maxv) r = maxv;
    res = r;
    pf  = p;
    inx = (s > 0 && (p % (64'd1 << s)) != 64'd0) ? 64'd1 : 64'd0;
  endtask

  task automatic drive(input int inst, input logic v, input int x, input int y, input int m);
    if (inst == 0) begin
      in_valid_a = v; op_x_a = 6'(x); op_y_a = 6'(y); round_mode_a = m[0];
    end else begin
      in_valid_b = v; op_x_b = 4'(x); op_y_b = 4'(y); round_mode_b = m[0];
    end
  endtask

  task automatic set_oready(input int inst, input logic r);
    if (inst == 0) out_ready_a = r;
    else           out_ready_b = r;
  endtask

  task automatic observe(input int inst, output logic ov, output logic ir,
                         output logic [63:0] res, output logic [63:0] inx, output logic [63:0] pf);
    if (inst == 0) begin
      ov = out_valid_a; ir = in_ready_a;
      res = 64'(result_a); inx = 64'(inexact_a); pf = 64'(product_full_a);
    end else begin
      ov = out_valid_b; ir = in_ready_b;
      res = 64'(result_b); inx = 64'(inexact_b); pf = 64'(product_full_b);
    end
  endtask

  // One full transaction: accept, scramble operands, time the latency,
  // hold back-pressure for `hold` cycles with a competing request, then hand off.
  task automatic run_op(input int inst, input int x, input int y, input int m, input int hold);
    logic ov, ir;
    logic [63:0] res, inx, pf, e_res, e_inx, e_pf;
    int n, w;
    w = (inst != 0) ? 4 : 6;
    model(inst, x, y, m, e_res, e_inx, e_pf);
    observe(inst, ov, ir, res, inx, pf);
    check("in_ready_idle", ir, 1);
    drive(inst, 1'b1, x, y, m);
    @(posedge clk); #1;
    drive(inst, 1'b0, int'($urandom), int'($urandom), int'($urandom_range(0, 1)));
    n = 0;
    observe(inst, ov, ir, res, inx, pf);
    check("in_ready_busy", ir, 0);
    while (!ov && n < 100) begin
      @(posedge clk); #1;
      n++;
      observe(inst, ov, ir, res, inx, pf);
    end
    check("out_valid_seen", ov, 1);
    check("latency", 64'(n), 64'(w + 1));
    check("result", res, e_res);
    check("inexact", inx, e_inx);
    check("product_full", pf, e_pf);
    for (int k = 0; k < hold; k++) begin
      drive(inst, 1'b1, int'($urandom), int'($urandom), int'($urandom_range(0, 1)));
      @(posedge clk); #1;
      observe(inst, ov, ir, res, inx, pf);
      check("bp_out_valid", ov, 1);
      check("bp_in_ready", ir, 0);
      check("bp_result", res, e_res);
      check("bp_inexact", inx, e_inx);
      check("bp_product", pf, e_pf);
    end
    set_oready(inst, 1'b1);
    @(posedge clk); #1;
    set_oready(inst, 1'b0);
    drive(inst, 1'b0, 0, 0, 0);
    observe(inst, ov, ir, res, inx, pf);
    check("post_out_valid", ov, 0);
    check("post_in_ready", ir, 1);
    check("post_result_held", res, e_res);
    check("post_product_held", pf, e_pf);
  endtask

  task automatic check_zero(input int inst);
    logic ov, ir;
    logic [63:0] res, inx, pf;
    observe(inst, ov, ir, res, inx, pf);
    check("rst_in_ready", ir, 1);
    check("rst_out_valid", ov, 0);
    check("rst_result", res, 0);
    check("rst_inexact", inx, 0);
    check("rst_product", pf, 0);
  endtask

  initial begin
    logic ov, ir;
    logic [63:0] res, inx, pf;
    reset = 1'b1;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    #3 reset = 1'b0;
    #1;
    check_zero(0);
    check_zero(1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(0, 63, 63, 0, 0);
    run_op(0, 45, 27, 0, 0);
    run_op(0, 45, 27, 1, 0);
    run_op(0, 0, 50, 1, 0);
    run_op(1, 15, 15, 1, 0);
    run_op(1, 15, 14, 1, 0);
    run_op(0, 37, 19, 1, 5);

    // Abort an operation mid-multiply; it must never surface.
    drive(0, 1'b1, 33, 21, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    observe(0, ov, ir, res, inx, pf);
    check("mid_mul_in_ready", ir, 0);
    reset = 1'b0;
    #1;
    check_zero(0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      observe(0, ov, ir, res, inx, pf);
      check("abort_no_valid", ov, 0);
    end
    run_op(0, 12, 5, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int inst, x, y;
      inst = int'($urandom_range(0, 1));
      x = (inst != 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 63));
      y = (inst != 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 63));
      run_op(inst, x, y, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
